// File: rtl/fifo_refill_scheduler_pkg.sv
// Shared types for the frame FIFO refill scheduler: FSM state encoding and
// the DDR read-port burst length width.
package fifo_refill_scheduler_pkg;

   localparam int LEN_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_REQ,
      ST_DATA,
      ST_DONE
   } state_t;

endpackage

// File: rtl/refill_credit_chk.sv
// Burst sizing and FIFO credit test: len = min(BURST_LEN, remaining) and
// whether a burst of that length still fits on top of the current level.
module refill_credit_chk
   import fifo_refill_scheduler_pkg::*;
#(
   parameter int BURST_LEN = 16,
   parameter int DEPTH_W   = 10,
   parameter int REM_W     = 20
) (
   input  logic [REM_W-1:0]   remaining,
   input  logic [DEPTH_W:0]   level,
   output logic [LEN_W-1:0]   len,
   output logic               fits
);

   localparam int SUM_W = DEPTH_W + 2;
   localparam logic [SUM_W-1:0] CAPACITY = {2'b01, {DEPTH_W{1'b0}}};

   logic [SUM_W-1:0] sum;

   // NOTE: every output gets a value on every path, so no latch can form.
   always_comb begin
      if (32'(remaining) < 32'(BURST_LEN)) begin
         len = LEN_W'(remaining);
      end else begin
         len = LEN_W'(BURST_LEN);
      end
      // One spare bit keeps level+len from wrapping before the compare.
      sum  = {1'b0, level} + SUM_W'(len);
      fits = (sum <= CAPACITY);
   end

endmodule

// File: rtl/fifo_refill_scheduler.sv
// Write-side refill controller: issues one DDR read burst at a time while the
// FIFO has room and forwards returned beats into the FIFO, one frame per start.
module fifo_refill_scheduler
   import fifo_refill_scheduler_pkg::*;
#(
   parameter int                ADDR_W      = 28,
   parameter int                DATA_W      = 64,
   parameter int                DEPTH_W     = 10,
   parameter int                BURST_LEN   = 16,
   parameter int                FRAME_BEATS = 518400,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                BEAT_BYTES  = 8
) (
   input  logic               wr_clk,
   input  logic               wr_rst,
   input  logic               frame_start,
   input  logic [DEPTH_W:0]   wr_water_level,
   output logic               rd_req,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic [LEN_W-1:0]   rd_len,
   input  logic               rd_ack,
   input  logic               rd_data_valid,
   input  logic [DATA_W-1:0]  rd_data,
   output logic               fifo_wr_en,
   output logic [DATA_W-1:0]  fifo_wr_data,
   output logic               frame_done,
   output logic               busy,
   output logic               overflow_err
);

   localparam int                REM_W     = $clog2(FRAME_BEATS + 1);
   localparam logic [REM_W-1:0]  FRAME_REM = REM_W'(FRAME_BEATS);
   localparam logic [DEPTH_W:0]  FULL      = {1'b1, {DEPTH_W{1'b0}}};

   state_t             state, state_nx;
   logic [ADDR_W-1:0]  next_addr;
   logic [REM_W-1:0]   remaining;
   logic [REM_W-1:0]   remaining_nx;
   logic [LEN_W-1:0]   beat_cnt;
   logic               restart_pend;
   logic [LEN_W-1:0]   chk_len;
   logic               chk_fits;
   logic               launch;
   logic               last_beat;
   logic               restart;
   logic               load_frame;

   refill_credit_chk #(
      .BURST_LEN (BURST_LEN),
      .DEPTH_W   (DEPTH_W),
      .REM_W     (REM_W)
   ) u_credit (
      .remaining (remaining),
      .level     (wr_water_level),
      .len       (chk_len),
      .fits      (chk_fits)
   );

   assign launch       = (state == ST_CHECK) && !frame_start && chk_fits;
   assign last_beat    = (state == ST_DATA) && rd_data_valid && (beat_cnt == LEN_W'(1));
   assign restart      = restart_pend || frame_start;
   assign remaining_nx = remaining - REM_W'(rd_len);
   assign load_frame   = (frame_start && (state == ST_IDLE || state == ST_CHECK || state == ST_DONE))
                      || (last_beat && restart);

   // NOTE: reset is sampled inside the clocked block, so it is synchronous.
   always_ff @(posedge wr_clk) begin
      if (wr_rst) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      rd_req     = (state == ST_REQ);
      busy       = (state != ST_IDLE);
      frame_done = (state == ST_DONE) && !frame_start;
      unique case (state)
         ST_IDLE:  if (frame_start) state_nx = ST_CHECK;
         ST_CHECK: if (launch) state_nx = ST_REQ;
         ST_REQ:   if (rd_ack) state_nx = ST_DATA;
         ST_DATA: begin
            if (last_beat) begin
               if (!restart && remaining_nx == '0) state_nx = ST_DONE;
               else                               state_nx = ST_CHECK;
            end
         end
         ST_DONE:  state_nx = frame_start ? ST_CHECK : ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge wr_clk) begin
      if (wr_rst) begin
         rd_addr      <= BASE_ADDR;
         rd_len       <= '0;
         next_addr    <= BASE_ADDR;
         remaining    <= '0;
         beat_cnt     <= '0;
         restart_pend <= 1'b0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         overflow_err <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;

         if (load_frame) begin
            next_addr <= BASE_ADDR;
            remaining <= FRAME_REM;
         end else if (last_beat) begin
            next_addr <= next_addr + ADDR_W'(rd_len) * ADDR_W'(BEAT_BYTES);
            remaining <= remaining_nx;
         end

         if (launch) begin
            rd_addr <= next_addr;
            rd_len  <= chk_len;
         end

         if (state == ST_REQ && rd_ack) beat_cnt <= rd_len;

         if (state == ST_DATA && rd_data_valid) begin
            beat_cnt <= beat_cnt - LEN_W'(1);
            // A pending restart drains the rest of the burst without writing it.
            if (!restart_pend) begin
               fifo_wr_en   <= 1'b1;
               fifo_wr_data <= rd_data;
               if (wr_water_level == FULL) overflow_err <= 1'b1;
            end
         end

         if (last_beat) begin
            restart_pend <= 1'b0;
         end else if ((state == ST_REQ || state == ST_DATA) && frame_start) begin
            restart_pend <= 1'b1;
         end
      end
   end

endmodule
